// File: rtl/led_pattern_sequencer_if.sv
// Settings and LED write bus between the board top, the pattern sequencer
// and the ws2812b strip driver.
interface led_pattern_sequencer_if #(
    parameter int NB_LEDS = 15
);
    localparam int STEP_W = $clog2(NB_LEDS) + 1;

    logic              enable;
    logic [1:0]        mode;
    logic [23:0]       color_a;
    logic [23:0]       color_b;
    logic [23:0]       color;
    logic [31:0]       nb_led;
    logic              write;
    logic              frame_done;
    logic [STEP_W-1:0] step;
    logic              busy;

    modport master (
        input  enable,
        input  mode,
        input  color_a,
        input  color_b,
        output color,
        output nb_led,
        output write,
        output frame_done,
        output step,
        output busy
    );

    modport slave (
        output enable,
        output mode,
        output color_a,
        output color_b,
        input  color,
        input  nb_led,
        input  write,
        input  frame_done,
        input  step,
        input  busy
    );
endinterface

// File: rtl/led_pattern_sequencer.sv
// Animation engine (SOLID/BLINK/CHASE/FILL) that rewrites every LED of a
// ws2812b strip once per frame, then holds before the next frame.
module led_pattern_sequencer #(
    parameter int NB_LEDS     = 15,
    parameter int WRITE_GAP   = 32,
    parameter int HOLD_CYCLES = 16711680
) (
    input logic                     clk,
    input logic                     rst,
    led_pattern_sequencer_if.master bus
);
    localparam int SW = $clog2(NB_LEDS) + 1;
    localparam int GW = $clog2(WRITE_GAP) + 1;
    localparam int HW = $clog2(HOLD_CYCLES) + 1;

    localparam logic [SW-1:0] LAST_LED  = SW'(NB_LEDS - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(WRITE_GAP - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    localparam logic [1:0] M_SOLID = 2'd0;
    localparam logic [1:0] M_BLINK = 2'd1;
    localparam logic [1:0] M_CHASE = 2'd2;
    localparam logic [1:0] M_FILL  = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        GAP,
        HOLD
    } state_t;

    state_t      state_q, state_d;
    logic [SW-1:0] k_q, k_d;
    logic [SW-1:0] step_q, step_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [1:0]  mode_q, mode_d;
    logic [23:0] ca_q, ca_d;
    logic [23:0] cb_q, cb_d;
    logic [23:0] color_q, color_d;
    logic [31:0] nb_led_q, nb_led_d;
    logic        write_q, frame_done_q, busy_q;
    logic        start;

    function automatic logic [23:0] pick(
        input logic [1:0]    m,
        input logic [23:0]   a,
        input logic [23:0]   b,
        input logic [SW-1:0] s,
        input logic [SW-1:0] k
    );
        logic [23:0] c;
        c = a;
        unique case (m)
            M_SOLID: c = a;
            M_BLINK: c = s[0] ? b : a;
            M_CHASE: c = (k == s) ? a : b;
            M_FILL:  c = (k <= s) ? a : b;
            default: c = a;
        endcase
        return c;
    endfunction

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        step_d  = step_q;
        gap_d   = gap_q;
        hold_d  = hold_q;
        mode_d  = mode_q;
        ca_d    = ca_q;
        cb_d    = cb_q;
        start   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.enable) start = 1'b1;
            end
            WRITE: begin
                state_d = GAP;
                gap_d   = '0;
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    if (k_q != LAST_LED) begin
                        k_d     = k_q + SW'(1);
                        state_d = WRITE;
                    end else begin
                        hold_d  = '0;
                        state_d = HOLD;
                    end
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    step_d = (step_q == LAST_LED) ? '0 : step_q + SW'(1);
                    if (bus.enable) begin
                        start = 1'b1;
                    end else begin
                        step_d  = '0;
                        state_d = IDLE;
                    end
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Settings are only ever captured at a frame boundary.
        if (start) begin
            mode_d  = bus.mode;
            ca_d    = bus.color_a;
            cb_d    = bus.color_b;
            k_d     = '0;
            state_d = WRITE;
        end

        color_d  = color_q;
        nb_led_d = nb_led_q;
        if (state_d == WRITE) begin
            color_d  = pick(mode_d, ca_d, cb_d, step_d, k_d);
            nb_led_d = 32'(k_d);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            k_q          <= '0;
            step_q       <= '0;
            gap_q        <= '0;
            hold_q       <= '0;
            mode_q       <= '0;
            ca_q         <= '0;
            cb_q         <= '0;
            color_q      <= '0;
            nb_led_q     <= '0;
            write_q      <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            step_q       <= step_d;
            gap_q        <= gap_d;
            hold_q       <= hold_d;
            mode_q       <= mode_d;
            ca_q         <= ca_d;
            cb_q         <= cb_d;
            color_q      <= color_d;
            nb_led_q     <= nb_led_d;
            write_q      <= (state_d == WRITE);
            frame_done_q <= (state_d == HOLD) && (state_q != HOLD);
            busy_q       <= (state_d != IDLE);
        end
    end

    assign bus.color      = color_q;
    assign bus.nb_led     = nb_led_q;
    assign bus.write      = write_q;
    assign bus.frame_done = frame_done_q;
    assign bus.step       = step_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Bench for led_pattern_sequencer: frame timing and colours are predicted
// from per-frame settings with plain cycle arithmetic.
module tb_led_pattern_sequencer;
    localparam int NB = 4;
    localparam int G  = 2;
    localparam int H  = 5;
    localparam int SW = $clog2(NB) + 1;
    localparam int L  = NB * (G + 1) + H;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    logic [1:0]  fm[8];
    logic [23:0] fa[8];
    logic [23:0] fb[8];

    led_pattern_sequencer_if #(.NB_LEDS(NB)) u_if ();

    led_pattern_sequencer #(
        .NB_LEDS    (NB),
        .WRITE_GAP  (G),
        .HOLD_CYCLES(H)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(u_if.master)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] ref_color(input int f, input int led);
        int s;
        s = f % NB;
        case (fm[f])
            2'd0:    return fa[f];
            2'd1:    return (s % 2 == 0) ? fa[f] : fb[f];
            2'd2:    return (led == s) ? fa[f] : fb[f];
            default: return (led <= s) ? fa[f] : fb[f];
        endcase
    endfunction

    task automatic test_reset;
        rst = 1'b0;
        u_if.enable  = 1'b0;
        u_if.mode    = 2'd0;
        u_if.color_a = 24'h0;
        u_if.color_b = 24'h0;
        repeat (2) @(negedge clk);
        checks++;
        if ({u_if.write, u_if.frame_done, u_if.busy} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags got=%b exp=000",
                     {u_if.write, u_if.frame_done, u_if.busy});
        end
        checks++;
        if (u_if.color !== 24'h0 || u_if.nb_led !== 32'h0 || u_if.step !== SW'(0)) begin
            errors++;
            $display("FAIL reset_data color=%h nb_led=%0d step=%0d exp 0",
                     u_if.color, u_if.nb_led, u_if.step);
        end
        rst = 1'b1;
    endtask

    // Start a SOLID frame, then pull reset during the first GAP.
    task automatic test_reset_midframe;
        @(negedge clk);
        u_if.enable  = 1'b1;
        u_if.mode    = 2'd0;
        u_if.color_a = 24'hA5A5A5;
        repeat (2) @(negedge clk);
        checks++;
        if (u_if.busy !== 1'b1 || u_if.write !== 1'b0) begin
            errors++;
            $display("FAIL rst_pre_gap busy=%b write=%b exp busy=1 write=0",
                     u_if.busy, u_if.write);
        end
        rst = 1'b0;
        u_if.enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({u_if.write, u_if.frame_done, u_if.busy} !== 3'b000 ||
                u_if.color !== 24'h0 || u_if.nb_led !== 32'h0 ||
                u_if.step !== SW'(0)) begin
                errors++;
                $display("FAIL rst_mid cyc=%0d w=%b fd=%b busy=%b color=%h nb=%0d step=%0d exp all 0",
                         i, u_if.write, u_if.frame_done, u_if.busy,
                         u_if.color, u_if.nb_led, u_if.step);
            end
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (u_if.busy !== 1'b0 || u_if.write !== 1'b0) begin
            errors++;
            $display("FAIL rst_release busy=%b write=%b exp 0 0",
                     u_if.busy, u_if.write);
        end
    endtask

    // Runs n frames with settings fm/fa/fb[0..n-1]. Between sampling points
    // the inputs are scrambled (or, with midframe, enable drops and mode
    // turns to CHASE from the LED1 write on).
    task automatic test_animation(input string name, input int n, input bit midframe);
        for (int c = 0; c <= n * L + 2; c++) begin
            int f, pos, i, fnext, exp_step;
            bit in_run, exp_wr, exp_fd;
            @(negedge clk);
            in_run   = (c >= 1) && (c <= n * L);
            f        = in_run ? (c - 1) / L : 0;
            pos      = in_run ? (c - 1) % L : 0;
            i        = (pos / (G + 1) < NB) ? pos / (G + 1) : NB - 1;
            exp_wr   = in_run && (pos < NB * (G + 1)) && (pos % (G + 1) == 0);
            exp_fd   = in_run && (pos == NB * (G + 1));
            exp_step = in_run ? f % NB : 0;

            checks++;
            if (u_if.write !== exp_wr) begin
                errors++;
                $display("FAIL %s write c=%0d got=%b exp=%b", name, c, u_if.write, exp_wr);
            end
            checks++;
            if (u_if.busy !== in_run) begin
                errors++;
                $display("FAIL %s busy c=%0d got=%b exp=%b", name, c, u_if.busy, in_run);
            end
            checks++;
            if (u_if.frame_done !== exp_fd) begin
                errors++;
                $display("FAIL %s frame_done c=%0d got=%b exp=%b",
                         name, c, u_if.frame_done, exp_fd);
            end
            checks++;
            if (u_if.step !== SW'(exp_step)) begin
                errors++;
                $display("FAIL %s step c=%0d got=%0d exp=%0d", name, c, u_if.step, exp_step);
            end
            if (in_run) begin
                checks++;
                if (u_if.nb_led !== 32'(i)) begin
                    errors++;
                    $display("FAIL %s nb_led c=%0d got=%0d exp=%0d", name, c, u_if.nb_led, i);
                end
                checks++;
                if (u_if.color !== ref_color(f, i)) begin
                    errors++;
                    $display("FAIL %s color c=%0d led=%0d got=%h exp=%h",
                             name, c, i, u_if.color, ref_color(f, i));
                end
            end

            if (c == 0 || (in_run && pos == L - 1)) begin
                fnext = (c == 0) ? 0 : f + 1;
                if (fnext < n) begin
                    u_if.enable  = 1'b1;
                    u_if.mode    = fm[fnext];
                    u_if.color_a = fa[fnext];
                    u_if.color_b = fb[fnext];
                end else begin
                    u_if.enable  = 1'b0;
                    u_if.mode    = 2'($urandom);
                    u_if.color_a = 24'($urandom);
                end
            end else if (midframe && c < n * L) begin
                u_if.enable = (c < 4);
                if (c >= 4) begin
                    u_if.mode    = 2'd2;
                    u_if.color_a = 24'($urandom);
                    u_if.color_b = 24'($urandom);
                end
            end else begin
                u_if.enable  = (c < n * L) ? 1'($urandom) : 1'b0;
                u_if.mode    = 2'($urandom);
                u_if.color_a = 24'($urandom);
                u_if.color_b = 24'($urandom);
            end
        end
    endtask

    task automatic test_solid;
        for (int f = 0; f < 2; f++) begin
            fm[f] = 2'd0; fa[f] = 24'hFF0000; fb[f] = 24'($urandom);
        end
        test_animation("solid", 2, 1'b0);
    endtask

    task automatic test_chase;
        for (int f = 0; f < 5; f++) begin
            fm[f] = 2'd2; fa[f] = 24'h00FF00; fb[f] = 24'h000000;
        end
        test_animation("chase", 5, 1'b0);
    endtask

    task automatic test_blink;
        for (int f = 0; f < 3; f++) begin
            fm[f] = 2'd1; fa[f] = 24'hFFFFFF; fb[f] = 24'h0000FF;
        end
        test_animation("blink", 3, 1'b0);
    endtask

    task automatic test_fill;
        for (int f = 0; f < 4; f++) begin
            fm[f] = 2'd3; fa[f] = 24'h112233; fb[f] = 24'h000000;
        end
        test_animation("fill", 4, 1'b0);
    endtask

    task automatic test_midframe;
        fm[0] = 2'd0; fa[0] = 24'h3C5A7E; fb[0] = 24'h010203;
        test_animation("midframe", 1, 1'b1);
    endtask

    task automatic test_random;
        for (int f = 0; f < 8; f++) begin
            fm[f] = 2'($urandom_range(0, 3));
            fa[f] = 24'($urandom);
            fb[f] = 24'($urandom);
        end
        test_animation("random", 8, 1'b0);
    endtask

    initial begin
        test_reset();
        test_solid();
        test_chase();
        test_blink();
        test_fill();
        test_midframe();
        test_reset_midframe();
        test_random();
        test_solid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/led_pattern_sequencer.md
Name: led_pattern_sequencer

Overview:
Parametrised pattern generator that drives the single-LED write interface of the ws2812b strip driver (color, nb_led, write). It generalises the fixed two-colour demo sequencer into a runtime-selectable animation engine: SOLID, BLINK, CHASE and FILL. Each animation step rewrites every LED of the strip, then holds for a programmable time. It sits between the board top level (mode/colour settings) and the ws2812b instance.

Parameters:
NB_LEDS, 15, number of LEDs on the strip (>=1); step index range is 0..NB_LEDS-1
WRITE_GAP, 32, idle cycles after each write strobe before the next one (>=1)
HOLD_CYCLES, 16711680, cycles spent in HOLD after each frame (>=1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active low (rst==0 resets on posedge clk)
enable  in  1  run animation; sampled only in IDLE and on the last HOLD cycle
mode  in  2  0=SOLID 1=BLINK 2=CHASE 3=FILL; latched at frame start
color_a  in  24  primary colour, GRB order as the driver expects; latched at frame start
color_b  in  24  secondary colour; latched at frame start
color  out  24  colour for LED nb_led, to ws2812b
nb_led  out  32  LED index 0..NB_LEDS-1, to ws2812b
write  out  1  one-cycle write strobe, to ws2812b
frame_done  out  1  one-cycle pulse on the first HOLD cycle
step  out  $clog2(NB_LEDS)+1  current animation step index
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (rst==0): state=IDLE; color=0, nb_led=0, write=0, frame_done=0, step=0, busy=0; latched mode/colours=0. Takes effect on the next edge, from any state including mid-frame.
- All outputs are registered. write is 1 only on WRITE-state cycles.
- States: IDLE, WRITE, GAP, HOLD.
- IDLE: if enable==1, latch mode/color_a/color_b, set led index k=0, go to WRITE. The first write=1 appears on the cycle after enable is seen.
- WRITE (1 cycle):
  - write=1, nb_led=k, color=f(mode,step,k).
  - Go to GAP with gap counter=0.
- GAP (WRITE_GAP cycles):
  - write=0; color and nb_led hold their values.
  - On the last GAP cycle: if k<NB_LEDS-1, set k=k+1 and go to WRITE; else go to HOLD.
  - Write period is therefore WRITE_GAP+1 cycles.
- HOLD (HOLD_CYCLES cycles): frame_done=1 on the first HOLD cycle only. On the last HOLD cycle:
  - step advances: step = (step==NB_LEDS-1) ? 0 : step+1.
  - If enable==1: re-latch inputs, k=0, go to WRITE.
  - Else: step=0 and go to IDLE.
- Timing, last write at cycle T: GAP on T+1..T+WRITE_GAP; HOLD on T+WRITE_GAP+1..T+WRITE_GAP+HOLD_CYCLES; next frame's LED0 write at T+WRITE_GAP+HOLD_CYCLES+1.
- Colour function f, using the latched values:
  - SOLID: color_a for every LED.
  - BLINK: color_a if step[0]==0, else color_b.
  - CHASE: color_a if k==step, else color_b.
  - FILL: color_a if k<=step, else color_b.
- Boundaries:
  - enable dropping inside WRITE/GAP/early HOLD is ignored; the frame and its full HOLD complete.
  - mode/colour changes mid-frame do not affect the current frame.
  - NB_LEDS=1: CHASE and FILL always give color_a; step stays 0.
  - BLINK with odd NB_LEDS: step wraps from NB_LEDS-1 to 0, so two consecutive frames show color_a. This is accepted.
- Counters are sized with $clog2 of their maximum plus 1 and never overflow.

Test Plan:
(Use NB_LEDS=4, WRITE_GAP=2, HOLD_CYCLES=5.)
1. Reset: hold rst=0 for 3 cycles during GAP of an active frame -> next cycle write=0, color=0, nb_led=0, step=0, busy=0, frame_done=0; FSM in IDLE.
2. SOLID, color_a=FF0000, enable=1 from cycle 0:
   - write pulses at cycles 1, 4, 7, 10 with nb_led 0..3, all color=FF0000.
   - frame_done at cycle 13.
   - next frame's LED0 write at cycle 18, with step=1.
3. CHASE, color_a=00FF00, color_b=000000:
   - frame step0 writes 00FF00, 0, 0, 0.
   - step1 writes 0, 00FF00, 0, 0.
   - after step3 frame, step wraps to 0.
4. BLINK, color_a=FFFFFF, color_b=0000FF -> frame0 all FFFFFF, frame1 all 0000FF, frame2 all FFFFFF.
5. FILL, color_a=112233, color_b=000000, at step2 -> LEDs 0..2 get 112233, LED3 gets 000000; at step3 all four get 112233.
6. Mid-frame changes, SOLID frame:
   - During LED1 write, drop enable and switch mode to CHASE.
   - Frame completes all 4 writes in SOLID colours; frame_done pulses; HOLD runs 5 cycles.
   - FSM then goes to IDLE with step=0, busy=0.
